t07_esp_loader: RTL and testbench

- Ingress stage between the ESP link and the t07 register file.
- Deserialises the 4-bit ESP nibble stream into 32-bit words, MSB nibble first.
- Writes the words into sequential register-file entries, starting at register 1 and ending at register 31.
- Raises a completion flag when the file is full; stalls writes while the register file is busy and reports framing faults.

---
 rtl/t07_esp_pkg.sv | 24 ++
 rtl/t07_esp_deser.sv | 69 ++++++
 rtl/t07_esp_loader.sv | 183 ++++++++++++++++++
 tb/tb_t07_esp_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t07_esp_pkg.sv
// Shared types and constants for the t07 ESP loader: FSM state encoding,
// datapath widths and the default register window.
package t07_esp_pkg;

    localparam int NIBBLE_W             = 4;
    localparam int WORD_W               = 32;
    localparam int REG_ADDR_W           = 5;
    localparam int DEF_NIBBLES_PER_WORD = 8;
    localparam int DEF_FIRST_REG        = 1;
    localparam int DEF_LAST_REG         = 31;
    localparam int DEF_IDLE_TIMEOUT     = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_DONE     = 2'd2,
        ST_DONE_ERR = 2'd3
    } esp_state_e;

    function automatic logic [REG_ADDR_W-1:0] reg_addr(input int idx);
        return REG_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/t07_esp_deser.sv
// Nibble deserialiser: MSB-first shifter, nibble counter and mid-word idle
// timeout. word_valid_o is combinational on the edge that samples the last nibble.
module t07_esp_deser
    import t07_esp_pkg::*;
#(
    parameter int NIBBLES_PER_WORD = DEF_NIBBLES_PER_WORD,
    parameter int IDLE_TIMEOUT     = DEF_IDLE_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en_i,
    input  logic [NIBBLE_W-1:0]                  nib_i,
    input  logic                                 nib_valid_i,
    output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0] word_o,
    output logic                                 word_valid_o,
    output logic                                 timeout_o
);

    localparam int W     = NIBBLE_W * NIBBLES_PER_WORD;
    localparam int CNT_W = $clog2(NIBBLES_PER_WORD + 1);
    localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES_PER_WORD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);

    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             take_s;

    assign take_s       = en_i & nib_valid_i;
    assign word_o       = {shift_q[W-NIBBLE_W-1:0], nib_i};
    assign word_valid_o = take_s & (cnt_q == CNT_LAST);
    // Timeout only arms while a partial word is held and input is enabled.
    assign timeout_o    = en_i & ~nib_valid_i & (cnt_q != '0) & (tmo_q == TMO_LAST);

    // Next-state for shifter, nibble count and idle counter.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        if (take_s) begin
            shift_d = word_o;
            tmo_d   = '0;
            cnt_d   = word_valid_o ? '0 : cnt_q + CNT_W'(1);
        end else if (timeout_o) begin
            shift_d = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end else if (en_i && (cnt_q != '0)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Deserialiser state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/t07_esp_loader.sv
// ESP-to-register-file loader: one-entry skid buffer, write pointer, load FSM.
// Define T07_ESP_CHECKSUM_EN to require a trailing XOR checksum word.
module t07_esp_loader
    import t07_esp_pkg::*;
#(
    parameter int NIBBLES_PER_WORD = DEF_NIBBLES_PER_WORD,
    parameter int FIRST_REG        = DEF_FIRST_REG,
    parameter int LAST_REG         = DEF_LAST_REG,
    parameter int IDLE_TIMEOUT     = DEF_IDLE_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NIBBLE_W-1:0]                  ESP_in,
    input  logic                                 esp_valid,
    input  logic                                 busy_i,
    output logic                                 reg_we,
    output logic [REG_ADDR_W-1:0]                reg_waddr,
    output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0] reg_wdata,
    output logic                                 load_done,
    output logic                                 frame_err
);

    localparam int WW = NIBBLE_W * NIBBLES_PER_WORD;
    localparam logic [REG_ADDR_W-1:0] FIRST_ADDR = reg_addr(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_ADDR  = reg_addr(LAST_REG);
`ifdef T07_ESP_CHECKSUM_EN
    localparam logic CKS_EN = 1'b1;
`else
    localparam logic CKS_EN = 1'b0;
`endif

    esp_state_e            state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  buf_cks_q, buf_cks_d;
    logic [WW-1:0]         buf_data_q, buf_data_d;
    logic [REG_ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
    logic                  acc_full_q, acc_full_d;
    logic [WW-1:0]         xor_q, xor_d;
    logic                  load_done_q, load_done_d;
    logic                  frame_err_q, frame_err_d;

    logic          en_s, word_valid_s, timeout_s;
    logic [WW-1:0] word_s;
    logic          wr_pend_s, drain_s, cks_take_s, free_s, want_s;

    assign en_s = (state_q == ST_IDLE) || (state_q == ST_SHIFT);

    t07_esp_deser #(
        .NIBBLES_PER_WORD (NIBBLES_PER_WORD),
        .IDLE_TIMEOUT     (IDLE_TIMEOUT)
    ) u_deser (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_s),
        .nib_i        (ESP_in),
        .nib_valid_i  (esp_valid),
        .word_o       (word_s),
        .word_valid_o (word_valid_s),
        .timeout_o    (timeout_s)
    );

    // A checksum word sitting in the buffer is consumed internally, never written.
    assign wr_pend_s  = buf_valid_q & ~buf_cks_q;
    assign drain_s    = wr_pend_s & ~busy_i;
    assign cks_take_s = buf_valid_q & buf_cks_q;
    assign free_s     = ~buf_valid_q | drain_s | cks_take_s;
    assign want_s     = word_valid_s & (~acc_full_q | CKS_EN);

    assign reg_we    = drain_s;
    assign reg_waddr = wr_pend_s ? buf_addr_q : '0;
    assign reg_wdata = wr_pend_s ? buf_data_q : '0;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

    // FSM next state plus skid buffer, pointer and checksum bookkeeping.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_cks_d   = buf_cks_q;
        buf_data_d  = buf_data_q;
        buf_addr_d  = buf_addr_q;
        ptr_d       = ptr_q;
        acc_full_d  = acc_full_q;
        xor_d       = xor_q;
        load_done_d = load_done_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (esp_valid && !word_valid_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (timeout_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (word_valid_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE, ST_DONE_ERR: state_d = state_q;
            default:              state_d = ST_IDLE;
        endcase

        if (drain_s) begin
            buf_valid_d = 1'b0;
            if (!CKS_EN && (buf_addr_q == LAST_ADDR)) begin
                state_d     = ST_DONE;
                load_done_d = 1'b1;
            end else begin
                load_done_d = load_done_q;
            end
        end else if (cks_take_s) begin
            buf_valid_d = 1'b0;
            buf_cks_d   = 1'b0;
            if (buf_data_q == xor_q) begin
                state_d     = ST_DONE;
                load_done_d = 1'b1;
            end else begin
                state_d     = ST_DONE_ERR;
                frame_err_d = 1'b1;
            end
        end else begin
            buf_valid_d = buf_valid_q;
        end

        // The pointer advances on acceptance; a dropped word never reserves an address.
        if (want_s && free_s) begin
            buf_valid_d = 1'b1;
            buf_data_d  = word_s;
            buf_addr_d  = ptr_q;
            buf_cks_d   = acc_full_q;
            if (!acc_full_q) begin
                xor_d = xor_q ^ word_s;
                if (ptr_q == LAST_ADDR) begin
                    acc_full_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + REG_ADDR_W'(1);
                end
            end else begin
                xor_d = xor_q;
            end
        end else if (want_s) begin
            frame_err_d = 1'b1;
        end else begin
            buf_data_d = buf_data_q;
        end
    end

    // Loader state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            buf_cks_q   <= 1'b0;
            buf_data_q  <= '0;
            buf_addr_q  <= '0;
            ptr_q       <= FIRST_ADDR;
            acc_full_q  <= 1'b0;
            xor_q       <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_cks_q   <= buf_cks_d;
            buf_data_q  <= buf_data_d;
            buf_addr_q  <= buf_addr_d;
            ptr_q       <= ptr_d;
            acc_full_q  <= acc_full_d;
            xor_q       <= xor_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_t07_esp_loader.sv
// Directed/randomised bench for t07_esp_loader; expected writes come from a
// queue-based model of the load sequence, observed writes from a negedge monitor.
module tb_t07_esp_loader;

    logic        clk;
    logic        rst;
    logic [3:0]  ESP_in;
    logic        esp_valid;
    logic        busy_i;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        load_done;
    logic        frame_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int fe_cnt   = 0;
    int next_addr;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    logic [31:0] w1, w2, w3, w4, cks;

    t07_esp_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ESP_in    (ESP_in),
        .esp_valid (esp_valid),
        .busy_i    (busy_i),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we === 1'b1) got_q.push_back({reg_waddr, reg_wdata});
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            miss_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) begin
            ESP_in    = w[i*4 +: 4];
            esp_valid = 1'b1;
            step();
        end
        esp_valid = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] w);
        exp_q.push_back({5'(next_addr), w});
        next_addr++;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        busy_i    = 1'b0;
        esp_valid = 1'b0;
        step();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        fe_cnt    = 0;
        next_addr = 1;
    endtask

    initial begin
        rst = 1'b1; ESP_in = 4'h0; esp_valid = 1'b0; busy_i = 1'b0;
        next_addr = 1;

        // reset state
        step();
        check("rst_we", 64'(reg_we), 64'd0);
        check("rst_waddr", 64'(reg_waddr), 64'd0);
        check("rst_wdata", 64'(reg_wdata), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        do_reset();

        // first word, one-cycle latency
        send_word(32'hAABBCCDD);
        model_write(32'hAABBCCDD);
        check("w1_we", 64'(reg_we), 64'd1);
        check("w1_waddr", 64'(reg_waddr), 64'd1);
        check("w1_wdata", 64'(reg_wdata), 64'hAABBCCDD);
        step();
        check("w1_we_off", 64'(reg_we), 64'd0);
        check_writes("first");

        // full load of 31 random back-to-back words
        do_reset();
        cks = 32'h0;
        for (int i = 0; i < 31; i++) begin
            w1 = $urandom;
            cks = cks ^ w1;
            model_write(w1);
            send_word(w1);
        end
        check("last_we", 64'(reg_we), 64'd1);
        check("last_waddr", 64'(reg_waddr), 64'd31);
        check("last_done_pre", 64'(load_done), 64'd0);
        step();
`ifndef T07_ESP_CHECKSUM_EN
        check("done_set", 64'(load_done), 64'd1);
        send_word($urandom);
        send_word($urandom);
        step();
        check("done_hold", 64'(load_done), 64'd1);
`else
        check("cks_done_pre", 64'(load_done), 64'd0);
        send_word(cks);
        check("cks_done_wait", 64'(load_done), 64'd0);
        step();
        check("cks_done_set", 64'(load_done), 64'd1);
        send_word($urandom);
        step();
`endif
        check_writes("full");
        check("full_ferr_cnt", 64'(fe_cnt), 64'd0);

        // stall around completion, then overflow during a second stall
        do_reset();
        busy_i = 1'b1;
        w1 = $urandom;
        send_word(w1);
        check("stall_we", 64'(reg_we), 64'd0);
        check("stall_waddr", 64'(reg_waddr), 64'd1);
        check("stall_wdata", 64'(reg_wdata), 64'(w1));
        step();
        step();
        check("stall_we2", 64'(reg_we), 64'd0);
        check("stall_wdata2", 64'(reg_wdata), 64'(w1));
        busy_i = 1'b0;
        #1;
        check("release_we", 64'(reg_we), 64'd1);
        step();
        check("release_we_off", 64'(reg_we), 64'd0);
        model_write(w1);
        busy_i = 1'b1;
        w2 = $urandom;
        w3 = $urandom;
        w4 = $urandom;
        send_word(w2);
        model_write(w2);
        send_word(w3);
        check("ovf_ferr", 64'(frame_err), 64'd1);
        check("ovf_waddr", 64'(reg_waddr), 64'd2);
        check("ovf_wdata", 64'(reg_wdata), 64'(w2));
        step();
        check("ovf_ferr_pulse", 64'(frame_err), 64'd0);
        busy_i = 1'b0;
        step();
        send_word(w4);
        model_write(w4);
        step();
        check_writes("stall");
        check("stall_ferr_cnt", 64'(fe_cnt), 64'd1);

        // mid-word idle timeout discards partial word
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ESP_in    = 4'($urandom_range(0, 15));
            esp_valid = 1'b1;
            step();
        end
        esp_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("tmo_ferr_early", 64'(frame_err), 64'd0);
        step();
        check("tmo_ferr", 64'(frame_err), 64'd1);
        step();
        check("tmo_ferr_pulse", 64'(frame_err), 64'd0);
        send_word(32'h12345678);
        model_write(32'h12345678);
        step();
        check_writes("tmo");
        check("tmo_ferr_cnt", 64'(fe_cnt), 64'd1);

        // reset mid-word
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ESP_in    = 4'hF;
            esp_valid = 1'b1;
            step();
        end
        esp_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstw_we", 64'(reg_we), 64'd0);
        check("rstw_wdata", 64'(reg_wdata), 64'd0);
        do_reset();
        w1 = $urandom;
        send_word(w1);
        model_write(w1);
        step();
        check_writes("rst_word");

        // reset mid-stall
        do_reset();
        busy_i = 1'b1;
        send_word($urandom);
        step();
        check("rsts_waddr_pend", 64'(reg_waddr), 64'd1);
        rst = 1'b1;
        #1;
        check("rsts_waddr", 64'(reg_waddr), 64'd0);
        check("rsts_wdata", 64'(reg_wdata), 64'd0);
        check("rsts_we", 64'(reg_we), 64'd0);
        do_reset();
        w2 = $urandom;
        send_word(w2);
        model_write(w2);
        step();
        check_writes("rst_stall");

`ifdef T07_ESP_CHECKSUM_EN
        // checksum mismatch
        do_reset();
        for (int i = 0; i < 31; i++) begin
            model_write(32'h11111111);
            send_word(32'h11111111);
        end
        step();
        send_word(32'h00000000);
        check("bad_ferr_wait", 64'(frame_err), 64'd0);
        step();
        check("bad_ferr", 64'(frame_err), 64'd1);
        check("bad_done", 64'(load_done), 64'd0);
        step();
        check("bad_done_hold", 64'(load_done), 64'd0);
        send_word($urandom);
        step();
        check_writes("bad_cks");
        check("bad_ferr_cnt", 64'(fe_cnt), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
